// File: rtl/dafx_gain_ramp_scheduler_if.sv
// Control/status bundle between the DAFX register bank and the gain ramp scheduler.
// Optional member overrun_count exists only when DAFX_RAMP_OVERRUN_CNT_EN is defined.
interface dafx_gain_ramp_scheduler_if #(
  parameter int NR_OF_CHANNELS_P = 3,
  parameter int GAIN_WIDTH_P     = 24,
  parameter int STEP_WIDTH_P     = 16
);
  localparam int S  = NR_OF_CHANNELS_P + 1;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  // No valid/ready pairs here: cr_* are static register levels, sample_tick and
  // cr_clear_overrun are one-cycle strobes, every status output is registered.
  logic [S*GAIN_WIDTH_P-1:0] cr_target_gain;
  logic [STEP_WIDTH_P-1:0]   cr_ramp_step;
  logic                      cr_ramp_enable;
  logic                      sample_tick;
  logic                      cr_clear_overrun;
  logic [S*GAIN_WIDTH_P-1:0] mix_gain;
  logic                      ramp_busy;
  logic                      ramp_done_irq;
  logic                      tick_overrun;
`ifdef DAFX_RAMP_OVERRUN_CNT_EN
  logic [15:0]               overrun_count;
`endif
  logic                      dbg_state;
  logic [CW-1:0]             dbg_slot;

  modport master (
    output cr_target_gain, cr_ramp_step, cr_ramp_enable, sample_tick, cr_clear_overrun,
    input  mix_gain, ramp_busy, ramp_done_irq, tick_overrun,
`ifdef DAFX_RAMP_OVERRUN_CNT_EN
    input  overrun_count,
`endif
    input  dbg_state, dbg_slot
  );

  modport slave (
    input  cr_target_gain, cr_ramp_step, cr_ramp_enable, sample_tick, cr_clear_overrun,
    output mix_gain, ramp_busy, ramp_done_irq, tick_overrun,
`ifdef DAFX_RAMP_OVERRUN_CNT_EN
    output overrun_count,
`endif
    output dbg_state, dbg_slot
  );
endinterface

// File: rtl/dafx_gain_ramp_scheduler.sv
// Round-robin gain ramper: one slot per clock after each sample tick, stepping toward target.
// Optional macro DAFX_RAMP_OVERRUN_CNT_EN adds a saturating dropped-tick counter.
module dafx_gain_ramp_scheduler #(
  parameter int NR_OF_CHANNELS_P = 3,
  parameter int GAIN_WIDTH_P     = 24,
  parameter int STEP_WIDTH_P     = 16
) (
  input logic clk,
  input logic rst_n,
  dafx_gain_ramp_scheduler_if.slave bus
);
  localparam int S    = NR_OF_CHANNELS_P + 1;
  localparam int W    = GAIN_WIDTH_P;
  localparam int CW   = (S > 1) ? $clog2(S) : 1;
  localparam int CMPW = (STEP_WIDTH_P > W + 1) ? STEP_WIDTH_P : W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_ctr;
  logic [S-1:0][W-1:0] r_gain;
  logic                r_changed;
  logic                r_busy;
  logic                r_irq;
  logic                r_overrun;

  logic [S-1:0][W-1:0] w_tgt;
  logic                w_bypass;
  logic [W-1:0]        w_cur;
  logic [W-1:0]        w_next;
  logic                w_slot_chg;
  logic                w_last;
  logic                w_all_eq_after;
  logic                w_any_ne;
  logic                w_drop;

  // Difference is formed one bit wider than the gain so it can never wrap.
  function automatic logic [W-1:0] f_ramp(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                          input logic [STEP_WIDTH_P-1:0] step);
    logic            up;
    logic [CMPW-1:0] diff;
    logic [CMPW-1:0] stp;
    up   = (tgt >= cur);
    diff = CMPW'(up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt}));
    stp  = CMPW'(step);
    if (diff <= stp)  return tgt;
    else if (up)      return cur + stp[W-1:0];
    else              return cur - stp[W-1:0];
  endfunction

  assign w_tgt      = bus.cr_target_gain;
  assign w_bypass   = !bus.cr_ramp_enable || (bus.cr_ramp_step == '0);
  assign w_cur      = r_gain[r_ctr];
  assign w_next     = f_ramp(w_cur, w_tgt[r_ctr], bus.cr_ramp_step);
  assign w_slot_chg = (w_next != w_cur);
  assign w_last     = (r_ctr == CW'(S - 1));
  assign w_drop     = bus.sample_tick && (r_state == ST_SWEEP);

  always_comb begin
    w_all_eq_after = 1'b1;
    w_any_ne       = 1'b0;
    for (int k = 0; k < S; k++) begin
      if (CW'(k) == r_ctr) w_all_eq_after = w_all_eq_after && (w_next == w_tgt[k]);
      else                 w_all_eq_after = w_all_eq_after && (r_gain[k] == w_tgt[k]);
      w_any_ne = w_any_ne || (r_gain[k] != w_tgt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ctr     <= '0;
      r_gain    <= '0;
      r_changed <= 1'b0;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_busy <= w_any_ne;
      r_irq  <= 1'b0;
      // Bypass follows targets on every clock, so the sweep itself must stay hands-off.
      if (w_bypass) r_gain <= w_tgt;
      case (r_state)
        ST_IDLE: begin
          if (bus.sample_tick) begin
            r_state   <= ST_SWEEP;
            r_ctr     <= '0;
            r_changed <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (!w_bypass) begin
            r_gain[r_ctr] <= w_next;
            if (w_slot_chg) r_changed <= 1'b1;
            if (w_last)     r_irq <= (r_changed || w_slot_chg) && w_all_eq_after;
          end
          if (w_last) begin
            r_state <= ST_IDLE;
            r_ctr   <= '0;
          end else begin
            r_ctr <= r_ctr + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ctr   <= '0;
        end
      endcase
      if (w_drop)                    r_overrun <= 1'b1;
      else if (bus.cr_clear_overrun) r_overrun <= 1'b0;
    end
  end

`ifdef DAFX_RAMP_OVERRUN_CNT_EN
  logic [15:0] r_ovr_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_cnt <= '0;
    end else if (w_drop) begin
      if (bus.cr_clear_overrun)     r_ovr_cnt <= 16'd1;
      else if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end else if (bus.cr_clear_overrun) begin
      r_ovr_cnt <= '0;
    end
  end
  assign bus.overrun_count = r_ovr_cnt;
`endif

  assign bus.mix_gain      = r_gain;
  assign bus.ramp_busy     = r_busy;
  assign bus.ramp_done_irq = r_irq;
  assign bus.tick_overrun  = r_overrun;
  assign bus.dbg_state     = (r_state == ST_SWEEP);
  assign bus.dbg_slot      = r_ctr;
endmodule

// File: tb/tb_dafx_gain_ramp_scheduler.sv
// Directed + randomized bench for dafx_gain_ramp_scheduler with a per-tick slot model.
// Optional checks for overrun_count are compiled when DAFX_RAMP_OVERRUN_CNT_EN is defined.
module tb_dafx_gain_ramp_scheduler;
  localparam int NR = 3;
  localparam int W  = 24;
  localparam int SW = 16;
  localparam int S  = NR + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dafx_gain_ramp_scheduler_if #(.NR_OF_CHANNELS_P(NR), .GAIN_WIDTH_P(W), .STEP_WIDTH_P(SW)) bus ();

  dafx_gain_ramp_scheduler #(.NR_OF_CHANNELS_P(NR), .GAIN_WIDTH_P(W), .STEP_WIDTH_P(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0]  m_gain [S];
  logic [W-1:0]  m_tgt  [S];
  logic          m_en;
  logic [SW-1:0] m_step;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Spec rule: move one step toward target, landing exactly on it when within a step.
  function automatic logic [W-1:0] move(input logic [W-1:0] c, input logic [W-1:0] t,
                                        input logic [SW-1:0] s);
    longint lc, lt, ls;
    lc = longint'(c); lt = longint'(t); ls = longint'(s);
    if (lt >= lc) return (lt - lc <= ls) ? t : W'(lc + ls);
    else          return (lc - lt <= ls) ? t : W'(lc - ls);
  endfunction

  function automatic bit model_bypass();
    return !m_en || (m_step == '0);
  endfunction

  task automatic drive_ctrl();
    for (int k = 0; k < S; k++) bus.cr_target_gain[k*W +: W] = m_tgt[k];
    bus.cr_ramp_enable = m_en;
    bus.cr_ramp_step   = m_step;
    @(negedge clk);
    if (model_bypass()) for (int k = 0; k < S; k++) m_gain[k] = m_tgt[k];
  endtask

  function automatic logic [W-1:0] dut_slot(input int k);
    return bus.mix_gain[k*W +: W];
  endfunction

  // One tick, then gap cycles checking each slot switches exactly k+1 cycles after the tick.
  task automatic run_tick(input string tag, input int gap);
    logic [W-1:0] old_g [S];
    logic [W-1:0] new_g [S];
    bit byp, chg, alleq, exp_irq, exp_busy;
    byp = model_bypass(); chg = 0; alleq = 1;
    for (int k = 0; k < S; k++) begin
      old_g[k] = m_gain[k];
      new_g[k] = byp ? m_tgt[k] : move(m_gain[k], m_tgt[k], m_step);
      if (new_g[k] != old_g[k]) chg = 1;
      if (new_g[k] != m_tgt[k]) alleq = 0;
    end
    exp_irq = !byp && chg && alleq;
    @(negedge clk); bus.sample_tick = 1'b1;
    @(negedge clk); bus.sample_tick = 1'b0;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      for (int k = 0; k < S; k++)
        chk($sformatf("%s_c%0d_slot%0d", tag, i, k), 32'(dut_slot(k)),
            32'((k < i) ? new_g[k] : old_g[k]));
      chk($sformatf("%s_c%0d_irq", tag, i), 32'(bus.ramp_done_irq),
          32'((i == S) ? exp_irq : 1'b0));
    end
    exp_busy = 0;
    for (int k = 0; k < S; k++) begin
      m_gain[k] = new_g[k];
      if (m_gain[k] != m_tgt[k]) exp_busy = 1;
    end
    chk({tag, "_busy"}, 32'(bus.ramp_busy), 32'(exp_busy));
  endtask

  task automatic check_overrun(input string tag, input logic flag, input logic [15:0] cnt);
    chk({tag, "_flag"}, 32'(bus.tick_overrun), 32'(flag));
`ifdef DAFX_RAMP_OVERRUN_CNT_EN
    chk({tag, "_cnt"}, 32'(bus.overrun_count), 32'(cnt));
`else
    if (cnt != cnt) $display("unreachable");
`endif
  endtask

  initial begin
    logic [W-1:0] redir_exp [4];
    redir_exp[0] = 24'h400; redir_exp[1] = 24'h300; redir_exp[2] = 24'h200; redir_exp[3] = 24'h200;

    // clock/reset
    rst_n = 1'b0;
    bus.cr_target_gain = '0; bus.cr_ramp_step = '0; bus.cr_ramp_enable = 1'b0;
    bus.sample_tick = 1'b0;  bus.cr_clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < S; k++) chk($sformatf("rst_slot%0d", k), 32'(dut_slot(k)), 32'h0);
    chk("rst_busy", 32'(bus.ramp_busy), 32'h0);
    chk("rst_irq", 32'(bus.ramp_done_irq), 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'h0);
    chk("rst_slot_ctr", 32'(bus.dbg_slot), 32'h0);
    check_overrun("rst_ovr", 1'b0, 16'd0);
    rst_n = 1'b1;
    for (int k = 0; k < S; k++) begin m_gain[k] = '0; m_tgt[k] = '0; end
    m_en = 1'b0; m_step = '0;
    @(negedge clk);

    // basic ramp: 0 -> 0x100 in 0x40 steps, ticks every 10 cycles
    for (int k = 0; k < S; k++) m_tgt[k] = 24'h000100;
    m_en = 1'b1; m_step = 16'h0040;
    drive_ctrl();
    for (int t = 1; t <= 4; t++) begin
      run_tick($sformatf("ramp_t%0d", t), 8);
      for (int k = 0; k < S; k++)
        chk($sformatf("ramp_t%0d_abs%0d", t, k), 32'(dut_slot(k)), 32'h40 * t);
    end

    // no undershoot on the way down
    m_tgt[2] = 24'h0000F0;
    drive_ctrl();
    run_tick("down", 6);
    chk("down_abs", 32'(dut_slot(2)), 32'h0000F0);

    // bypass: jump next clock, busy clears two cycles later, tick gives no irq
    m_en = 1'b0; m_tgt[0] = 24'hABCDEF;
    for (int k = 0; k < S; k++) bus.cr_target_gain[k*W +: W] = m_tgt[k];
    bus.cr_ramp_enable = 1'b0;
    @(negedge clk);
    chk("byp_jump", 32'(dut_slot(0)), 32'hABCDEF);
    @(negedge clk);
    chk("byp_busy", 32'(bus.ramp_busy), 32'h0);
    for (int k = 0; k < S; k++) m_gain[k] = m_tgt[k];
    run_tick("byp_tick", 6);

    // redirect mid-ramp on slot 1
    for (int k = 0; k < S; k++) m_tgt[k] = '0;
    drive_ctrl();
    m_en = 1'b1; m_step = 16'h0100; m_tgt[1] = 24'h001000;
    drive_ctrl();
    for (int t = 1; t <= 5; t++) run_tick($sformatf("redir_up%0d", t), 6);
    chk("redir_at5", 32'(dut_slot(1)), 32'h500);
    m_tgt[1] = 24'h000200;
    drive_ctrl();
    for (int t = 0; t < 4; t++) begin
      run_tick($sformatf("redir_dn%0d", t), 6);
      chk($sformatf("redir_abs%0d", t), 32'(dut_slot(1)), 32'(redir_exp[t]));
    end

    // overrun: second tick 2 cycles after the first is dropped
    @(negedge clk); bus.sample_tick = 1'b1;
    @(negedge clk); bus.sample_tick = 1'b0;
    @(negedge clk); bus.sample_tick = 1'b1;
    @(negedge clk); bus.sample_tick = 1'b0;
    check_overrun("ovr1", 1'b1, 16'd1);
    repeat (6) @(negedge clk);
    chk("ovr1_slot1_hold", 32'(dut_slot(1)), 32'h200);
    bus.cr_clear_overrun = 1'b1;
    @(negedge clk); bus.cr_clear_overrun = 1'b0;
    check_overrun("ovr1_clr", 1'b0, 16'd0);
    // two drops, then a drop coinciding with clear
    @(negedge clk); bus.sample_tick = 1'b1;
    @(negedge clk); bus.sample_tick = 1'b0;
    @(negedge clk); bus.sample_tick = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.sample_tick = 1'b0;
    check_overrun("ovr2", 1'b1, 16'd2);
    repeat (6) @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk); bus.sample_tick = 1'b0;
    @(negedge clk); bus.sample_tick = 1'b1; bus.cr_clear_overrun = 1'b1;
    @(negedge clk); bus.sample_tick = 1'b0; bus.cr_clear_overrun = 1'b0;
    check_overrun("ovr_setwins", 1'b1, 16'd1);
    repeat (6) @(negedge clk);
    bus.cr_clear_overrun = 1'b1;
    @(negedge clk); bus.cr_clear_overrun = 1'b0;
    check_overrun("ovr_final_clr", 1'b0, 16'd0);

    // asynchronous reset in the middle of a sweep
    for (int k = 0; k < S; k++) m_tgt[k] = 24'h000800;
    drive_ctrl();
    run_tick("pre_rst", 6);
    bus.sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.sample_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < S; k++) chk($sformatf("midrst_slot%0d", k), 32'(dut_slot(k)), 32'h0);
    chk("midrst_state", 32'(bus.dbg_state), 32'h0);
    chk("midrst_ctr", 32'(bus.dbg_slot), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < S; k++) m_gain[k] = '0;
    run_tick("post_rst", 6);

    // randomized control and targets, legal tick spacing
    for (int it = 0; it < 40; it++) begin
      m_en   = ($urandom_range(0, 7) != 0);
      m_step = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      for (int k = 0; k < S; k++)
        if ($urandom_range(0, 1) == 1)
          m_tgt[k] = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 24'hFFFFFF))
                                                 : m_gain[k] + 24'($urandom_range(0, 16'h3FF));
      drive_ctrl();
      for (int t = 0; t < int'($urandom_range(1, 3)); t++)
        run_tick($sformatf("rnd%0d_%0d", it, t), int'($urandom_range(S + 1, S + 4)));
    end
    check_overrun("rnd_ovr", 1'b0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
